// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-side burst arbiter.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Channel index width; a single channel pair still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from last_grant+1, wrapping.
module rr_pick
  import fifo_rd_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last_grant,
  output logic [CH_W-1:0] grant,
  output logic            found
);

  int idx;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (req[idx[CH_W-1:0]]) begin
        grant = idx[CH_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Burst round-robin arbiter over N_CH show-ahead FIFO read ports.
// Optional FIFO_RD_ARB_PRIO_EN: prefer channels that are not almost-empty.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_BURST  = 8,
  localparam int CH_W       = ch_w(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [N_CH*DATA_WIDTH-1:0] ch_rd_data,
  input  logic [N_CH-1:0]            ch_empty,
  input  logic [N_CH-1:0]            ch_almost_empty,
  output logic [N_CH-1:0]            ch_rd_en,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic [CH_W-1:0]            m_chan,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy
);

  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t                            state, state_nxt;
  logic [CNT_W-1:0]                  cnt;
  logic [CH_W-1:0]                   last_grant, pick;
  logic                              found, slot_free, pop, g_empty, cnt_end;
  logic [N_CH-1:0]                   elig;
  logic [N_CH-1:0][DATA_WIDTH-1:0]   words;

  assign words = ch_rd_data;

`ifdef FIFO_RD_ARB_PRIO_EN
  logic [N_CH-1:0] healthy;
  assign healthy = ~ch_empty & ~ch_almost_empty;
  assign elig    = (|healthy) ? healthy : ~ch_empty;
`else
  logic unused_ae;
  assign unused_ae = ^ch_almost_empty;
  assign elig      = ~ch_empty;
`endif

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req        (elig),
    .last_grant (last_grant),
    .grant      (pick),
    .found      (found)
  );

  // While in BURST, last_grant is the granted channel.
  assign slot_free = !m_valid || m_ready;
  assign g_empty   = ch_empty[last_grant];
  assign cnt_end   = (cnt == CNT_LAST);
  assign busy      = (state == BURST) || m_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable && found) state_nxt = BURST;
      BURST: if (g_empty || (slot_free && cnt_end)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = !rst && (state == BURST) && slot_free && !g_empty;
    ch_rd_en = '0;
    if (pop) ch_rd_en[last_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= '0;
      m_chan     <= '0;
      cnt        <= '0;
      last_grant <= CH_W'(N_CH - 1);
    end else begin
      if (state == IDLE && state_nxt == BURST) begin
        last_grant <= pick;
        cnt        <= '0;
      end
      if (pop) begin
        m_valid <= 1'b1;
        m_data  <= words[last_grant];
        m_chan  <= last_grant;
        m_last  <= cnt_end;
        cnt     <= cnt + CNT_W'(1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed scoreboard bench for fifo_rd_arbiter with behavioural show-ahead FIFOs.
module tb_fifo_rd_arbiter;

  localparam int N = 4;
  localparam int DW = 16;
  localparam int DEPTH = 64;

  typedef struct {
    logic [1:0]  c;
    logic        l;
    logic [15:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst, enable, m_ready;
  logic [N*DW-1:0] ch_rd_data;
  logic [N-1:0]    ch_empty, ch_almost_empty, ch_rd_en;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_chan;
  logic            m_last, m_valid, busy;

  logic [15:0] mem [N][DEPTH];
  int          wp [N];
  int          rp [N];
  exp_t        exp_q[$];
  int          xfer_cyc[$];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_rd_data(ch_rd_data),
    .ch_empty(ch_empty), .ch_almost_empty(ch_almost_empty), .ch_rd_en(ch_rd_en),
    .m_data(m_data), .m_chan(m_chan), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy)
  );

  for (genvar i = 0; i < N; i++) begin : g_fifo
    assign ch_empty[i] = (rp[i] == wp[i]);
    assign ch_rd_data[i*DW +: DW] = mem[i][rp[i]];
    initial begin
      wp[i] = 0;
      rp[i] = 0;
      for (int j = 0; j < DEPTH; j++) mem[i][j] = '0;
    end
    always @(posedge clk) if (ch_rd_en[i] && rp[i] < wp[i]) rp[i] <= rp[i] + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] w(input int c, input int k);
    return 16'(c * 256 + k);
  endfunction

  task automatic load(input int c, input int base, input int n);
    for (int j = 0; j < n; j++) begin
      mem[c][wp[c]] = w(c, base + j);
      wp[c] = wp[c] + 1;
    end
  endtask

  task automatic expect_words(input int c, input int base, input int n, input bit last_end);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.c = 2'(c);
      e.d = w(c, base + j);
      e.l = last_end && (j == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    #1;
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (xfer_cyc.size() >= n) break;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Monitor: invariants on pops plus in-order scoreboard of transfers.
  always @(negedge clk) if (!rst) begin
    exp_t e;
    if (ch_rd_en != '0) begin
      chk("rd_en_onehot", 32'($onehot(ch_rd_en)), 1);
      chk("rd_en_on_empty", 32'(ch_rd_en & ch_empty), 0);
    end
    if (m_valid && m_ready) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("spurious_word", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("word", {13'd0, m_chan, m_last, m_data}, {13'd0, e.c, e.l, e.d});
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1; ch_almost_empty = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_chan", m_chan, 0);
    chk("rst_rd_en", ch_rd_en, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Full burst, one bubble, then a short tail burst.
    xfer_cyc.delete();
    load(0, 1, 10);
    expect_words(0, 1, 8, 1);
    expect_words(0, 9, 2, 0);
    wait_done("t1");
    chk("t1_count", xfer_cyc.size(), 10);
    if (xfer_cyc.size() == 10) begin
      chk("t1_tput", xfer_cyc[7] - xfer_cyc[0], 7);
      chk("t1_gap", xfer_cyc[8] - xfer_cyc[7], 2);
    end

    // Four full channels: grants 0,1,2,3.
    do_reset();
    xfer_cyc.delete();
    load(0, 11, 8); load(1, 1, 8); load(2, 1, 8); load(3, 1, 8);
    for (int c = 0; c < N; c++) expect_words(c, (c == 0) ? 11 : 1, 8, 1);
    wait_done("t2");
    chk("t2_count", xfer_cyc.size(), 32);

    // Short burst on ch2, then busy drops.
    load(2, 9, 3);
    expect_words(2, 9, 3, 0);
    wait_done("t3");
    @(negedge clk);
    chk("t3_busy", busy, 0);

    // Backpressure for five cycles mid-burst.
    xfer_cyc.delete();
    load(1, 9, 8);
    expect_words(1, 9, 8, 1);
    wait_xfers(3);
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rd_en", ch_rd_en, 0);
      chk("stall_valid", m_valid, 1);
      if (exp_q.size() > 0) chk("stall_data", {m_chan, m_data}, {exp_q[0].c, exp_q[0].d});
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done("t4");
    chk("t4_count", xfer_cyc.size(), 8);

    // Almost-empty preference with last_grant = 0.
    do_reset();
    load(0, 19, 1);
    expect_words(0, 19, 1, 0);
    wait_done("t5a");
    ch_almost_empty = 4'b0010;
    load(1, 17, 2); load(3, 9, 2);
`ifdef FIFO_RD_ARB_PRIO_EN
    expect_words(3, 9, 2, 0);
    expect_words(1, 17, 2, 0);
`else
    expect_words(1, 17, 2, 0);
    expect_words(3, 9, 2, 0);
`endif
    wait_done("t5b");
    ch_almost_empty = '0;

    // Enable low blocks new grants.
    enable = 1'b0;
    load(2, 12, 1);
    repeat (4) begin
      @(negedge clk);
      chk("dis_rd_en", ch_rd_en, 0);
      chk("dis_busy", busy, 0);
    end
    @(posedge clk); #1 enable = 1'b1;
    expect_words(2, 12, 1, 0);
    wait_done("t6");

    // Reset mid-burst on ch1: held word dropped, ch0 wins next.
    do_reset();
    xfer_cyc.delete();
    load(1, 19, 8);
    expect_words(1, 19, 8, 1);
    wait_xfers(3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rd_en", ch_rd_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    load(0, 20, 2);
    expect_words(0, 20, 2, 0);
    expect_words(1, 23, 4, 0);
    @(negedge clk);
    chk("midrst_valid", m_valid, 0);
    wait_done("t7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of FIFO read ports arbitrated (2..16).
REQ-002 Parameter DATA_WIDTH, default 16, FIFO word width.
REQ-003 Parameter MAX_BURST, default 8, maximum words per grant (1..256).
REQ-004 clk  input  1  single clock; all logic on posedge clk; FIFO read sides share this clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  permits new grants; a burst in progress is unaffected.
REQ-007 ch_rd_data  input  N_CH*DATA_WIDTH  show-ahead FIFO data, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ch_empty  input  N_CH  per-channel FIFO empty.
REQ-009 ch_almost_empty  input  N_CH  per-channel FIFO almost-empty.
REQ-010 ch_rd_en  output  N_CH  per-channel pop strobe.
REQ-011 m_data  output  DATA_WIDTH  output word.
REQ-012 m_chan  output  CH_W  source channel of m_data.
REQ-013 m_last  output  1  final word of a full MAX_BURST burst.
REQ-014 m_valid  output  1  output word valid.
REQ-015 m_ready  input  1  downstream accept; transfer when m_valid && m_ready.
REQ-016 busy  output  1  high in BURST state or while m_valid.

Function
REQ-017 States IDLE and BURST only; reset state IDLE.
REQ-018 IDLE->BURST when enable high and an eligible channel exists; grant g = first eligible channel found searching upward, wrapping, from last_grant+1; burst counter cleared; last_grant <= g.
REQ-019 Output slot free = !m_valid || m_ready.
REQ-020 In BURST, when slot free and !ch_empty[g]: ch_rd_en[g]=1 that cycle; next cycle m_valid=1, m_data=word g, m_chan=g; counter increments.
REQ-021 Pop-to-m_valid latency exactly 1 cycle; sustained throughput 1 word/cycle while m_ready is high.
REQ-022 m_last=1 with the word popped when the counter equals MAX_BURST-1; BURST->IDLE that same cycle.
REQ-023 In BURST, ch_empty[g] high -> BURST->IDLE that cycle, no pop, no m_last (short burst).
REQ-024 m_valid && !m_ready: m_data, m_chan, m_last held stable; no pop.
REQ-025 ch_rd_en is zero or one-hot, never asserted for a channel whose ch_empty is high, never asserted in IDLE.
REQ-026 IDLE with no eligible channel or enable low: all ch_rd_en=0; an occupied output register still drains.
REQ-027 Counter width clog2(MAX_BURST+1); never wraps.

Reset
REQ-028 rst high: state IDLE, m_valid=0, m_last=0, m_data=0, m_chan=0, ch_rd_en=0, busy=0, counter=0, last_grant=N_CH-1 (channel 0 searched first).
REQ-029 rst mid-burst discards the held output word; no pop occurs in the rst cycle.

Configuration
REQ-030 Macro FIFO_RD_ARB_PRIO_EN defined: eligible = channels with !ch_empty && !ch_almost_empty if any exist, else channels with !ch_empty; round-robin within that set.
REQ-031 Macro undefined: eligible = !ch_empty; ch_almost_empty ignored (port retained).

Structure
REQ-032 Package fifo_rd_arb_pkg holds state enum (IDLE, BURST) and a CH_W function = max(1, clog2(N_CH)).
REQ-033 Sub-module rr_pick (request vector, last_grant -> grant index, found flag) is the only sub-module.

Verification
REQ-034 Reset; ch0 holds 10 words 0x0001..0x000A, m_ready=1 -> 8 words with m_chan=0, m_last on 0x0008, one IDLE cycle, then 0x0009,0x000A with no m_last.
REQ-035 ch0..ch3 each hold 8 words, m_ready=1 -> grants in order 0,1,2,3, each a full burst with m_last; 32 words, zero drops.
REQ-036 ch2 holds 3 words, others empty -> 3 words m_chan=2, m_last never asserted, return to IDLE, busy low after the last transfer.
REQ-037 m_ready low for 5 cycles mid-burst -> m_data stable, ch_rd_en all zero, no word lost or duplicated.
REQ-038 PRIO_EN: ch1 non-empty but almost_empty, ch3 above threshold, last_grant=0 -> ch3 granted first; without macro -> ch1 first.
REQ-039 rst asserted mid-burst on ch1 -> next cycle m_valid=0, ch_rd_en=0; the following grant goes to channel 0 if non-empty.
